opcode_translator: RTL and testbench
====================================

// Module: opcode_translator
// PURPOSE
//  Front end of the IE stage. Assembles raw 6502 instructions (opcode plus 0-2 operand bytes) from the fetch byte stream.
//  Translates each opcode into the simple_op/flag bundle that simple_op_decode consumes.
//  Presents one registered instruction at a time to IE over a valid/ready handshake.
// PARAMETERS
//  PC_W      16   width of the program counter / inst_pc
//  RESET_PC  16'h0000   PC value loaded at reset
// PORTS
//  clk             in   1    system clock; all state on rising edge
//  reset_n         in   1    asynchronous, active-low reset
//  byte_in         in   8    fetched byte
//  byte_valid      in   1    byte_in valid this cycle
//  byte_ready      out  1    translator accepts byte_in this cycle
//  flush           in   1    sync; discard partial and held instruction, reload PC
//  flush_pc        in   PC_W new PC applied on flush
//  inst_valid      out  1    instruction bundle valid
//  inst_ready      in   1    IE accepts bundle this cycle
//  simple_op       out  8    translated op code (ie_defs encoding)
//  mem_load_flag   out  1    operand sourced from memory
//  store_flag      out  3    001 mem, 010 A, 011 X, 100 Y, 111 P, 000 none
//  reg_load_flag   out  2    01 A, 10 X, 11 Y, 00 mem
//  alu_op          out  4    ALU op (ie_defs)
//  immediate_flag  out  1    operand is immediate
//  operand         out  16   {hi,lo}; unused bytes zero
//  inst_pc         out  PC_W address of opcode byte
//  illegal_op      out  1    see CONFIGURATION
// BEHAVIOUR
//  - Reset: state=OPC, pc=RESET_PC, inst_valid=0, all bundle outputs 0, illegal_op=0.
//  - FSM: OPC -> (len==1) EMIT | (len>=2) OPR1; OPR1 -> (len==2) EMIT | OPR2; OPR2 -> EMIT.
//  - In EMIT, a handshake (inst_valid&&inst_ready) returns the FSM to OPC.
//  - Byte accepted when byte_valid&&byte_ready. byte_ready = (state!=EMIT) || inst_ready.
//  - An opcode byte is therefore accepted in the same cycle the held bundle is consumed, giving 1 byte/clk sustained.
//  - pc increments by 1 per accepted byte and wraps 16'hFFFF->16'h0000. inst_pc latches pc when the opcode is accepted.
//  - Latency: inst_valid rises the cycle after the last byte of the instruction is accepted.
//  - Bundle outputs are registered. They are stable while inst_valid && !inst_ready.
//  - Length and flags come from the lookup of the opcode byte, registered at opcode accept.
//  - Operand lo is captured in OPR1 and operand hi in OPR2.
//  - flush has priority over everything in the cycle it is high:
//    state=OPC, inst_valid=0, pc=flush_pc.
//    byte_ready=0 that cycle, so no byte is accepted.
//  - byte_valid low mid-instruction holds state indefinitely; no timeout.
//  - Reset asserted mid-instruction discards the partial instruction immediately (async).
// CONFIGURATION
//  ILLEGAL_OP_TRAP_EN defined:
//    - an undocumented opcode emits simple_op=8'h22 (NOP), len 1, with illegal_op=1 alongside the bundle.
//    - illegal_op is sticky until reset or flush.
//  ILLEGAL_OP_TRAP_EN undefined:
//    - an undocumented opcode emits NOP 8'h22, len 1, silently; illegal_op tied 0.
// STRUCTURE
//  - ie_defs holds the following; no local duplicates:
//    - simple_op codes (incl. BCC..BVS, JMP);
//    - the store/reg-load flag encodings above;
//    - the FSM state enum;
//    - the bundle struct typedef.
//  - Sub-module opcode_rom: combinational 256-entry case.
//    - Input: opcode byte.
//    - Output: {valid_op, len[1:0], simple_op, mem_load_flag, store_flag, reg_load_flag, alu_op, immediate_flag}.
//  - Top holds the FSM, the PC counter and the output register.
// TESTING
//  - LDA #$42: bytes A9,42 streamed back-to-back, inst_ready=1 -> one bundle.
//    - immediate_flag=1, store_flag=010, operand=16'h0042.
//    - inst_pc=RESET_PC; inst_valid for 1 cycle.
//  - JMP $1234: 4C,34,12 -> simple_op=JMP, operand=16'h1234, is_branch-class.
//    - 3 bytes accepted in 3 clks; the following opcode is accepted in the EMIT cycle.
//  - INX (E8) with inst_ready=0 for 5 cycles:
//    - bundle (reg_load_flag=10, store_flag=011) held stable;
//    - byte_ready=0 throughout;
//    - resumes after ready.
//  - Flush: after the 4C,34 partial, pulse flush with flush_pc=16'h8000, then stream EA.
//    - No JMP bundle emitted.
//    - NOP bundle emitted with inst_pc=16'h8000.
//  - Wrap: flush_pc=16'hFFFF, stream AD,00,02.
//    - inst_pc=16'hFFFF; next opcode's inst_pc=16'h0002.
//  - Opcode 02 -> NOP bundle; illegal_op=1 with macro defined, 0 without. Reset mid-OPR1 -> all outputs 0.

Source files
------------

// File: rtl/opcode_translator_pkg.sv
// rtl/opcode_translator_pkg.sv - ie_defs: shared encodings for the IE front end
// Purpose: simple_op codes, ALU ops, store/reg-load flag encodings, translator
//          FSM states and the translated bundle struct. Imported by every file
//          of the opcode translator.
// Ports:   none (package)
package ie_defs;

  // simple_op codes
  localparam logic [7:0] OP_ADC = 8'h00, OP_AND = 8'h01, OP_ASL = 8'h02, OP_BCC = 8'h03;
  localparam logic [7:0] OP_BCS = 8'h04, OP_BEQ = 8'h05, OP_BIT = 8'h06, OP_BMI = 8'h07;
  localparam logic [7:0] OP_BNE = 8'h08, OP_BPL = 8'h09, OP_BRK = 8'h0A, OP_BVC = 8'h0B;
  localparam logic [7:0] OP_BVS = 8'h0C, OP_CLC = 8'h0D, OP_CLD = 8'h0E, OP_CLI = 8'h0F;
  localparam logic [7:0] OP_CLV = 8'h10, OP_CMP = 8'h11, OP_CPX = 8'h12, OP_CPY = 8'h13;
  localparam logic [7:0] OP_DEC = 8'h14, OP_DEX = 8'h15, OP_DEY = 8'h16, OP_EOR = 8'h17;
  localparam logic [7:0] OP_INC = 8'h18, OP_INX = 8'h19, OP_INY = 8'h1A, OP_JMP = 8'h1B;
  localparam logic [7:0] OP_JSR = 8'h1C, OP_LDA = 8'h1D, OP_LDX = 8'h1E, OP_LDY = 8'h1F;
  localparam logic [7:0] OP_LSR = 8'h20, OP_ORA = 8'h21, OP_NOP = 8'h22, OP_PHA = 8'h23;
  localparam logic [7:0] OP_PHP = 8'h24, OP_PLA = 8'h25, OP_PLP = 8'h26, OP_ROL = 8'h27;
  localparam logic [7:0] OP_ROR = 8'h28, OP_RTI = 8'h29, OP_RTS = 8'h2A, OP_SBC = 8'h2B;
  localparam logic [7:0] OP_SEC = 8'h2C, OP_SED = 8'h2D, OP_SEI = 8'h2E, OP_STA = 8'h2F;
  localparam logic [7:0] OP_STX = 8'h30, OP_STY = 8'h31, OP_TAX = 8'h32, OP_TAY = 8'h33;
  localparam logic [7:0] OP_TSX = 8'h34, OP_TXA = 8'h35, OP_TXS = 8'h36, OP_TYA = 8'h37;

  // ALU operations
  localparam logic [3:0] ALU_NONE = 4'h0, ALU_ADD = 4'h1, ALU_SUB = 4'h2, ALU_AND = 4'h3;
  localparam logic [3:0] ALU_OR   = 4'h4, ALU_XOR = 4'h5, ALU_SHL = 4'h6, ALU_SHR = 4'h7;
  localparam logic [3:0] ALU_ROL  = 4'h8, ALU_ROR = 4'h9, ALU_INC = 4'hA, ALU_DEC = 4'hB;
  localparam logic [3:0] ALU_CMP  = 4'hC, ALU_BIT = 4'hD, ALU_PASS = 4'hE;

  // Destination of the result
  localparam logic [2:0] STORE_NONE = 3'b000, STORE_MEM = 3'b001, STORE_A = 3'b010;
  localparam logic [2:0] STORE_X    = 3'b011, STORE_Y   = 3'b100, STORE_P = 3'b111;

  // Source register feeding the op
  localparam logic [1:0] RL_MEM = 2'b00, RL_A = 2'b01, RL_X = 2'b10, RL_Y = 2'b11;

  typedef enum logic [1:0] {
    S_OPC  = 2'd0,
    S_OPR1 = 2'd1,
    S_OPR2 = 2'd2,
    S_EMIT = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0] simple_op;
    logic       mem_load_flag;
    logic [2:0] store_flag;
    logic [1:0] reg_load_flag;
    logic [3:0] alu_op;
    logic       immediate_flag;
  } bundle_t;

  // Control-flow ops carry an address/offset operand, never a memory load.
  function automatic logic is_flow_op(input logic [7:0] op);
    return op inside {OP_BCC, OP_BCS, OP_BEQ, OP_BMI, OP_BNE, OP_BPL, OP_BVC, OP_BVS,
                      OP_JMP, OP_JSR, OP_BRK, OP_RTI, OP_RTS};
  endfunction

endpackage

// File: rtl/opcode_translator_if.sv
// rtl/opcode_translator_if.sv - byte stream, flush and instruction bundle bus
// Purpose: groups the fetch byte stream, flush control and the IE bundle.
// Ports (signals): byte_in/byte_valid/byte_ready, flush/flush_pc,
//   inst_valid/inst_ready, simple_op, mem_load_flag, store_flag,
//   reg_load_flag, alu_op, immediate_flag, operand, inst_pc, illegal_op.
// Modports: master = fetch/IE side, slave = translator.
interface opcode_translator_if #(parameter int PC_W = 16);
  logic [7:0]      byte_in;
  logic            byte_valid;
  logic            byte_ready;
  logic            flush;
  logic [PC_W-1:0] flush_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [7:0]      simple_op;
  logic            mem_load_flag;
  logic [2:0]      store_flag;
  logic [1:0]      reg_load_flag;
  logic [3:0]      alu_op;
  logic            immediate_flag;
  logic [15:0]     operand;
  logic [PC_W-1:0] inst_pc;
  logic            illegal_op;

  modport master (
    output byte_in, byte_valid, flush, flush_pc, inst_ready,
    input  byte_ready, inst_valid, simple_op, mem_load_flag, store_flag,
           reg_load_flag, alu_op, immediate_flag, operand, inst_pc, illegal_op
  );

  modport slave (
    input  byte_in, byte_valid, flush, flush_pc, inst_ready,
    output byte_ready, inst_valid, simple_op, mem_load_flag, store_flag,
           reg_load_flag, alu_op, immediate_flag, operand, inst_pc, illegal_op
  );
endinterface

// File: rtl/opcode_translator_rom.sv
// rtl/opcode_translator_rom.sv - combinational 6502 opcode lookup
// Purpose: maps an opcode byte to {valid_op, len, bundle}. Undocumented
//          opcodes give valid_op=0, len=1 and a flag-free NOP bundle.
// Ports: opcode (in 8), valid_op (out 1), len (out 2), bundle (out bundle_t)
module opcode_rom
  import ie_defs::*;
(
  input  logic [7:0] opcode,
  output logic       valid_op,
  output logic [1:0] len,
  output bundle_t    bundle
);

  // 6502 opcodes are aaabbbcc: bbb selects the addressing mode within a cc group
  logic [2:0] bbb;
  logic [1:0] cc;
  assign bbb = opcode[4:2];
  assign cc  = opcode[1:0];

  logic [7:0] op;
  logic [3:0] alu;
  logic [2:0] st;
  logic [1:0] rl;
  logic       shift, imm;

  always_comb begin
    op = OP_NOP; alu = ALU_NONE; st = STORE_NONE; rl = RL_MEM;
    valid_op = 1'b1; shift = 1'b0; len = 2'd1; imm = 1'b0;
    case (opcode)
      8'h69, 8'h65, 8'h75, 8'h6D, 8'h7D, 8'h79, 8'h61, 8'h71: begin op = OP_ADC; alu = ALU_ADD; st = STORE_A; rl = RL_A; end
      8'hE9, 8'hE5, 8'hF5, 8'hED, 8'hFD, 8'hF9, 8'hE1, 8'hF1: begin op = OP_SBC; alu = ALU_SUB; st = STORE_A; rl = RL_A; end
      8'h29, 8'h25, 8'h35, 8'h2D, 8'h3D, 8'h39, 8'h21, 8'h31: begin op = OP_AND; alu = ALU_AND; st = STORE_A; rl = RL_A; end
      8'h09, 8'h05, 8'h15, 8'h0D, 8'h1D, 8'h19, 8'h01, 8'h11: begin op = OP_ORA; alu = ALU_OR;  st = STORE_A; rl = RL_A; end
      8'h49, 8'h45, 8'h55, 8'h4D, 8'h5D, 8'h59, 8'h41, 8'h51: begin op = OP_EOR; alu = ALU_XOR; st = STORE_A; rl = RL_A; end
      8'hC9, 8'hC5, 8'hD5, 8'hCD, 8'hDD, 8'hD9, 8'hC1, 8'hD1: begin op = OP_CMP; alu = ALU_CMP; st = STORE_P; rl = RL_A; end
      8'hA9, 8'hA5, 8'hB5, 8'hAD, 8'hBD, 8'hB9, 8'hA1, 8'hB1: begin op = OP_LDA; alu = ALU_PASS; st = STORE_A; end
      8'h85, 8'h95, 8'h8D, 8'h9D, 8'h99, 8'h81, 8'h91:        begin op = OP_STA; st = STORE_MEM; rl = RL_A; end
      8'hA2, 8'hA6, 8'hB6, 8'hAE, 8'hBE: begin op = OP_LDX; alu = ALU_PASS; st = STORE_X; end
      8'hA0, 8'hA4, 8'hB4, 8'hAC, 8'hBC: begin op = OP_LDY; alu = ALU_PASS; st = STORE_Y; end
      8'h86, 8'h96, 8'h8E: begin op = OP_STX; st = STORE_MEM; rl = RL_X; end
      8'h84, 8'h94, 8'h8C: begin op = OP_STY; st = STORE_MEM; rl = RL_Y; end
      8'hE0, 8'hE4, 8'hEC: begin op = OP_CPX; alu = ALU_CMP; st = STORE_P; rl = RL_X; end
      8'hC0, 8'hC4, 8'hCC: begin op = OP_CPY; alu = ALU_CMP; st = STORE_P; rl = RL_Y; end
      8'h24, 8'h2C:        begin op = OP_BIT; alu = ALU_BIT; st = STORE_P; rl = RL_A; end
      8'h0A, 8'h06, 8'h16, 8'h0E, 8'h1E: begin op = OP_ASL; alu = ALU_SHL; shift = 1'b1; end
      8'h4A, 8'h46, 8'h56, 8'h4E, 8'h5E: begin op = OP_LSR; alu = ALU_SHR; shift = 1'b1; end
      8'h2A, 8'h26, 8'h36, 8'h2E, 8'h3E: begin op = OP_ROL; alu = ALU_ROL; shift = 1'b1; end
      8'h6A, 8'h66, 8'h76, 8'h6E, 8'h7E: begin op = OP_ROR; alu = ALU_ROR; shift = 1'b1; end
      8'hE6, 8'hF6, 8'hEE, 8'hFE: begin op = OP_INC; alu = ALU_INC; st = STORE_MEM; end
      8'hC6, 8'hD6, 8'hCE, 8'hDE: begin op = OP_DEC; alu = ALU_DEC; st = STORE_MEM; end
      8'hE8: begin op = OP_INX; alu = ALU_INC;  st = STORE_X; rl = RL_X; end
      8'hCA: begin op = OP_DEX; alu = ALU_DEC;  st = STORE_X; rl = RL_X; end
      8'hC8: begin op = OP_INY; alu = ALU_INC;  st = STORE_Y; rl = RL_Y; end
      8'h88: begin op = OP_DEY; alu = ALU_DEC;  st = STORE_Y; rl = RL_Y; end
      8'hAA: begin op = OP_TAX; alu = ALU_PASS; st = STORE_X; rl = RL_A; end
      8'hA8: begin op = OP_TAY; alu = ALU_PASS; st = STORE_Y; rl = RL_A; end
      8'h8A: begin op = OP_TXA; alu = ALU_PASS; st = STORE_A; rl = RL_X; end
      8'h98: begin op = OP_TYA; alu = ALU_PASS; st = STORE_A; rl = RL_Y; end
      8'hBA: begin op = OP_TSX; alu = ALU_PASS; st = STORE_X; end
      8'h9A: begin op = OP_TXS; alu = ALU_PASS; rl = RL_X; end
      8'h48: begin op = OP_PHA; st = STORE_MEM; rl = RL_A; end
      8'h08: begin op = OP_PHP; st = STORE_MEM; end
      8'h68: begin op = OP_PLA; alu = ALU_PASS; st = STORE_A; end
      8'h28: begin op = OP_PLP; st = STORE_P; end
      8'h90: op = OP_BCC;  8'hB0: op = OP_BCS;  8'hF0: op = OP_BEQ;  8'h30: op = OP_BMI;
      8'hD0: op = OP_BNE;  8'h10: op = OP_BPL;  8'h50: op = OP_BVC;  8'h70: op = OP_BVS;
      8'h4C, 8'h6C: op = OP_JMP;
      8'h20: op = OP_JSR;  8'h60: op = OP_RTS;  8'h40: op = OP_RTI;  8'h00: op = OP_BRK;
      8'h18: begin op = OP_CLC; st = STORE_P; end
      8'hD8: begin op = OP_CLD; st = STORE_P; end
      8'h58: begin op = OP_CLI; st = STORE_P; end
      8'hB8: begin op = OP_CLV; st = STORE_P; end
      8'h38: begin op = OP_SEC; st = STORE_P; end
      8'hF8: begin op = OP_SED; st = STORE_P; end
      8'h78: begin op = OP_SEI; st = STORE_P; end
      8'hEA: op = OP_NOP;
      default: valid_op = 1'b0;
    endcase

    // Shifts/rotates work on A in accumulator mode (bbb=010), otherwise read-modify-write
    if (shift && bbb == 3'b010) begin
      st = STORE_A; rl = RL_A;
    end else if (shift) begin
      st = STORE_MEM; rl = RL_MEM;
    end

    if (valid_op) begin
      if (cc == 2'b01) begin
        len = (bbb == 3'b011 || bbb[2:1] == 2'b11) ? 2'd3 : 2'd2;
        imm = (bbb == 3'b010);
      end else begin
        case (bbb)
          // row 0: BRK/RTI/RTS implied, JSR absolute, A0/C0/E0/A2 immediate
          3'b000:  begin
            len = (opcode == 8'h20) ? 2'd3 : (opcode[7] ? 2'd2 : 2'd1);
            imm = opcode[7];
          end
          3'b010, 3'b110: len = 2'd1;
          3'b011, 3'b111: len = 2'd3;
          default:        len = 2'd2;
        endcase
      end
    end

    bundle.simple_op      = op;
    bundle.mem_load_flag  = valid_op && !imm && (len != 2'd1) && !is_flow_op(op) &&
                            !(op inside {OP_STA, OP_STX, OP_STY});
    bundle.store_flag     = st;
    bundle.reg_load_flag  = rl;
    bundle.alu_op         = alu;
    bundle.immediate_flag = imm;
  end

endmodule

// File: rtl/opcode_translator.sv
// rtl/opcode_translator.sv - assembles 6502 instructions and emits translated bundles
// Purpose: collects opcode + 0..2 operand bytes, translates via opcode_rom and
//          holds one registered bundle for IE over a valid/ready handshake.
// Ports: clk, reset_n (async active-low), bus (opcode_translator_if.slave):
//        byte stream in, flush/flush_pc, bundle out with inst_valid/inst_ready.
// Config: ILLEGAL_OP_TRAP_EN - when defined, undocumented opcodes set a sticky
//         illegal_op (cleared by reset or flush); otherwise illegal_op is 0.
module opcode_translator
  import ie_defs::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic                clk,
  input logic                reset_n,
  opcode_translator_if.slave bus
);

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc, inst_pc_q;
  bundle_t         bundle_q, rom_bundle;
  logic [15:0]     operand_q;
  logic [1:0]      len_q, rom_len;
  logic            rom_valid;
  logic            byte_ready, byte_fire, opc_fire, inst_fire;

  opcode_rom u_rom (
    .opcode   (bus.byte_in),
    .valid_op (rom_valid),
    .len      (rom_len),
    .bundle   (rom_bundle)
  );

  // A new opcode may enter in the same cycle the held bundle is taken.
  assign byte_ready = !bus.flush && ((state != S_EMIT) || bus.inst_ready);
  assign byte_fire  = bus.byte_valid && byte_ready;
  assign opc_fire   = byte_fire && (state == S_OPC || state == S_EMIT);
  assign inst_fire  = (state == S_EMIT) && bus.inst_ready;

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = S_OPC;
    end else begin
      case (state)
        S_OPC, S_EMIT: begin
          if (opc_fire)       state_nxt = (rom_len == 2'd1) ? S_EMIT : S_OPR1;
          else if (inst_fire) state_nxt = S_OPC;
        end
        S_OPR1:  if (byte_fire) state_nxt = (len_q == 2'd2) ? S_EMIT : S_OPR2;
        S_OPR2:  if (byte_fire) state_nxt = S_EMIT;
        default: state_nxt = S_OPC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_OPC;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc        <= RESET_PC;
      inst_pc_q <= '0;
      bundle_q  <= '0;
      operand_q <= '0;
      len_q     <= 2'd1;
    end else if (bus.flush) begin
      pc <= bus.flush_pc;
    end else begin
      if (byte_fire) pc <= pc + 1'b1;
      if (opc_fire) begin
        bundle_q  <= rom_bundle;
        len_q     <= rom_len;
        inst_pc_q <= pc;
        operand_q <= '0;
      end else if (byte_fire && state == S_OPR1) begin
        operand_q[7:0] <= bus.byte_in;
      end else if (byte_fire && state == S_OPR2) begin
        operand_q[15:8] <= bus.byte_in;
      end
    end
  end

`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_q;
  // Set with the opcode accept so it appears together with the NOP bundle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   illegal_q <= 1'b0;
    else if (bus.flush)             illegal_q <= 1'b0;
    else if (opc_fire && !rom_valid) illegal_q <= 1'b1;
  end
  assign bus.illegal_op = illegal_q;
`else
  logic unused_rom_valid;
  assign unused_rom_valid = rom_valid;
  assign bus.illegal_op   = 1'b0;
`endif

  assign bus.byte_ready     = byte_ready;
  assign bus.inst_valid     = (state == S_EMIT);
  assign bus.simple_op      = bundle_q.simple_op;
  assign bus.mem_load_flag  = bundle_q.mem_load_flag;
  assign bus.store_flag     = bundle_q.store_flag;
  assign bus.reg_load_flag  = bundle_q.reg_load_flag;
  assign bus.alu_op         = bundle_q.alu_op;
  assign bus.immediate_flag = bundle_q.immediate_flag;
  assign bus.operand        = operand_q;
  assign bus.inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_opcode_translator.sv
// tb/tb_opcode_translator.sv - self-checking bench for opcode_translator
module tb_opcode_translator;

`ifdef ILLEGAL_OP_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  opcode_translator_if #(.PC_W(16)) bus();

  opcode_translator #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int extras = 0;

  logic [7:0]  byte_q[$];
  logic [63:0] exp_q[$];
  logic [15:0] m_pc;
  bit          m_ill;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outv();
    return {12'h0, bus.simple_op, bus.mem_load_flag, bus.store_flag, bus.reg_load_flag,
            bus.alu_op, bus.immediate_flag, bus.operand, bus.inst_pc, bus.illegal_op};
  endfunction

  // Reference table: {simple_op, mem_load, store, reg_load, alu, imm} and length
  function automatic void ref_info(input logic [7:0] op, output int len,
                                   output logic [18:0] f, output bit ill);
    ill = 1'b0;
    case (op)
      8'hA9: begin len = 2; f = {8'h1D, 1'b0, 3'b010, 2'b00, 4'hE, 1'b1}; end // LDA #
      8'hAD: begin len = 3; f = {8'h1D, 1'b1, 3'b010, 2'b00, 4'hE, 1'b0}; end // LDA abs
      8'h4C: begin len = 3; f = {8'h1B, 1'b0, 3'b000, 2'b00, 4'h0, 1'b0}; end // JMP
      8'hE8: begin len = 1; f = {8'h19, 1'b0, 3'b011, 2'b10, 4'hA, 1'b0}; end // INX
      8'hEA: begin len = 1; f = {8'h22, 1'b0, 3'b000, 2'b00, 4'h0, 1'b0}; end // NOP
      8'h65: begin len = 2; f = {8'h00, 1'b1, 3'b010, 2'b01, 4'h1, 1'b0}; end // ADC zp
      8'h8D: begin len = 3; f = {8'h2F, 1'b0, 3'b001, 2'b01, 4'h0, 1'b0}; end // STA abs
      8'h0A: begin len = 1; f = {8'h02, 1'b0, 3'b010, 2'b01, 4'h6, 1'b0}; end // ASL A
      8'h06: begin len = 2; f = {8'h02, 1'b1, 3'b001, 2'b00, 4'h6, 1'b0}; end // ASL zp
      8'hF0: begin len = 2; f = {8'h05, 1'b0, 3'b000, 2'b00, 4'h0, 1'b0}; end // BEQ
      8'hC9: begin len = 2; f = {8'h11, 1'b0, 3'b111, 2'b01, 4'hC, 1'b1}; end // CMP #
      8'hB6: begin len = 2; f = {8'h1E, 1'b1, 3'b011, 2'b00, 4'hE, 1'b0}; end // LDX zp,Y
      8'h9A: begin len = 1; f = {8'h36, 1'b0, 3'b000, 2'b10, 4'hE, 1'b0}; end // TXS
      default: begin len = 1; f = {8'h22, 11'h0}; ill = 1'b1; end            // undocumented
    endcase
  endfunction

  task automatic push_insn(input logic [7:0] op, input logic [7:0] lo, input logic [7:0] hi);
    int len; logic [18:0] f; bit ill; logic [15:0] opd;
    ref_info(op, len, f, ill);
    m_ill = m_ill | (ill & TRAP_EN);
    opd = 16'h0;
    byte_q.push_back(op);
    if (len >= 2) begin byte_q.push_back(lo); opd[7:0] = lo; end
    if (len == 3) begin byte_q.push_back(hi); opd[15:8] = hi; end
    exp_q.push_back({12'h0, f, opd, m_pc, m_ill});
    m_pc = m_pc + 16'(len);
  endtask

  // Streams byte_q, consumes bundles against exp_q. hold = cycles inst_ready is
  // withheld while a bundle is shown.
  task automatic run(input int max_cyc, input bit rnd, input int hold,
                     output int cyc, output int vcnt);
    logic [63:0] held = '0;
    bit was_held = 1'b0;
    int h = hold;
    cyc = 0; vcnt = 0;
    while ((byte_q.size() != 0 || exp_q.size() != 0) && cyc < max_cyc) begin
      @(posedge clk); #1;
      bus.byte_valid = (byte_q.size() != 0) && (!rnd || $urandom_range(3) != 0);
      bus.byte_in    = (byte_q.size() != 0) ? byte_q[0] : 8'h00;
      if (bus.inst_valid && h > 0) begin
        bus.inst_ready = 1'b0; h--;
      end else begin
        bus.inst_ready = rnd ? ($urandom_range(2) != 0) : 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (bus.inst_valid) begin
        vcnt++;
        if (was_held) check("held_stable", outv(), held);
        if (!bus.inst_ready) check("byte_ready_held", 64'(bus.byte_ready), 64'd0);
        if (bus.inst_ready) begin
          if (exp_q.size() == 0) extras++;
          else check("bundle", outv(), exp_q.pop_front());
        end
      end
      was_held = bus.inst_valid && !bus.inst_ready;
      held = outv();
      if (bus.byte_valid && bus.byte_ready) void'(byte_q.pop_front());
    end
    check("run_drained", 64'(byte_q.size() + exp_q.size()), 64'd0);
    byte_q.delete(); exp_q.delete();
    @(posedge clk); #1;
    bus.byte_valid = 1'b0;
    bus.inst_ready = 1'b0;
  endtask

  task automatic do_flush(input logic [15:0] npc);
    @(posedge clk); #1;
    bus.flush = 1'b1; bus.flush_pc = npc;
    bus.byte_valid = 1'b1; bus.byte_in = 8'h12; bus.inst_ready = 1'b1;
    @(negedge clk);
    check("flush_byte_ready", 64'(bus.byte_ready), 64'd0);
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.byte_valid = 1'b0; bus.inst_ready = 1'b0;
    check("flush_inst_valid", 64'(bus.inst_valid), 64'd0);
    m_pc = npc; m_ill = 1'b0;
  endtask

  logic [7:0] pool [15] = '{8'hA9, 8'hAD, 8'h4C, 8'hE8, 8'hEA, 8'h65, 8'h8D, 8'h0A,
                            8'h06, 8'hF0, 8'hC9, 8'hB6, 8'h9A, 8'h02, 8'hFF};

  initial begin
    int cyc, vcnt;
    bus.byte_in = 8'h00; bus.byte_valid = 1'b0; bus.flush = 1'b0;
    bus.flush_pc = 16'h0; bus.inst_ready = 1'b0;
    m_pc = 16'h0000; m_ill = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outv(), 64'h0);
    check("reset_inst_valid", 64'(bus.inst_valid), 64'd0);
    check("reset_byte_ready", 64'(bus.byte_ready), 64'd1);
    @(posedge clk); #1 reset_n = 1'b1;

    // LDA #$42: 2 bytes then one bundle for exactly one cycle
    push_insn(8'hA9, 8'h42, 8'h00);
    run(50, 1'b0, 0, cyc, vcnt);
    check("lda_cycles", 64'(cyc), 64'd3);
    check("lda_valid_cycles", 64'(vcnt), 64'd1);
    @(negedge clk);
    check("lda_valid_drops", 64'(bus.inst_valid), 64'd0);

    // JMP $1234 then NOP: next opcode enters during the EMIT cycle
    push_insn(8'h4C, 8'h34, 8'h12);
    push_insn(8'hEA, 8'h00, 8'h00);
    run(50, 1'b0, 0, cyc, vcnt);
    check("jmp_nop_cycles", 64'(cyc), 64'd5);

    // INX held for 5 cycles with a NOP waiting behind it
    push_insn(8'hE8, 8'h00, 8'h00);
    push_insn(8'hEA, 8'h00, 8'h00);
    run(50, 1'b0, 5, cyc, vcnt);
    check("inx_hold_cycles", 64'(cyc), 64'd8);

    // Flush after a partial JMP
    @(posedge clk); #1 bus.byte_valid = 1'b1; bus.byte_in = 8'h4C;
    @(posedge clk); #1 bus.byte_in = 8'h34;
    do_flush(16'h8000);
    push_insn(8'hEA, 8'h00, 8'h00);
    run(50, 1'b0, 0, cyc, vcnt);
    check("flush_extra_bundles", 64'(extras), 64'd0);

    // PC wrap
    do_flush(16'hFFFF);
    push_insn(8'hAD, 8'h00, 8'h02);
    push_insn(8'hE8, 8'h00, 8'h00);
    run(50, 1'b0, 0, cyc, vcnt);

    // Undocumented opcode, sticky flag, cleared by flush
    do_flush(16'h0300);
    push_insn(8'h02, 8'h00, 8'h00);
    push_insn(8'hE8, 8'h00, 8'h00);
    run(50, 1'b0, 0, cyc, vcnt);
    do_flush(16'h0400);
    push_insn(8'hEA, 8'h00, 8'h00);
    run(50, 1'b0, 0, cyc, vcnt);

    // Random stream with random byte gaps and backpressure
    do_flush(16'($urandom));
    for (int i = 0; i < 150; i++)
      push_insn(pool[$urandom_range(14)], 8'($urandom), 8'($urandom));
    run(5000, 1'b1, 0, cyc, vcnt);
    check("random_extra_bundles", 64'(extras), 64'd0);

    // Async reset while waiting for the first operand
    @(posedge clk); #1 bus.byte_valid = 1'b1; bus.byte_in = 8'hAD;
    @(posedge clk); #1 bus.byte_valid = 1'b0;
    @(negedge clk); reset_n = 1'b0;
    #1;
    check("midreset_outputs", outv(), 64'h0);
    check("midreset_inst_valid", 64'(bus.inst_valid), 64'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    m_pc = 16'h0000; m_ill = 1'b0;
    push_insn(8'hA9, 8'h55, 8'h00);
    run(50, 1'b0, 0, cyc, vcnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
